// File: rtl/edge_conv_pkg.sv
// Shared types and constants for the 3x3 Sobel edge pipeline: kernel modes,
// frame FSM states and the Gx/Gy coefficient tables.
package edge_conv_pkg;

   typedef enum logic [1:0] {
      GX  = 2'd0,
      GY  = 2'd1,
      MAG = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Row 0 is the oldest line (top), column 0 the oldest pixel (left).
   localparam int GX_COEF [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int GY_COEF [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   // The reserved encoding behaves as the combined magnitude.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd0:    return GX;
         2'd1:    return GY;
         default: return MAG;
      endcase
   endfunction

endpackage

// File: rtl/edge_conv_pipe_line_fifo.sv
// Fixed-delay line store: a circular RAM whose single pointer is both read and
// write address, so each shift returns the word written DEPTH shifts earlier.
module line_fifo
   import edge_conv_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr <= '0;
      end else if (shift_en) begin
         ptr <= (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
      end
   end

   // NOTE: storage has no reset so it maps onto plain RAM; stale words are
   // masked because no result is issued before row 2 of a frame.
   always_ff @(posedge i_clk) begin
      if (shift_en) begin
         mem[ptr] <= wr_data;
      end
   end

   assign rd_data = mem[ptr];

endmodule

// File: rtl/edge_conv_pipe.sv
// Streaming 3x3 Sobel filter (Gx, Gy or |Gx|+|Gy|) with two-cycle latency.
// Define EDGE_CONV_SATURATE_EN to clamp results to 2^DATA_WIDTH-1.
module edge_conv_pipe
   import edge_conv_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic                  i_sof,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [1:0]            i_mode,
   output logic                  o_valid,
   output logic [DATA_WIDTH+2:0] o_data,
   output logic                  o_frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int SW = DATA_WIDTH + 4;
   localparam int OW = DATA_WIDTH + 3;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

   state_e        state;
   mode_e         mode_q;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          accept;
   logic          at_last;

   // A start-of-frame pixel is always (0,0), whatever the counters hold.
   assign accept  = i_valid && (i_sof || state != IDLE);
   assign cur_col = i_sof ? '0 : col;
   assign cur_row = i_sof ? '0 : row;
   assign at_last = (state == RUN) && !i_sof && (cur_row == LAST_ROW) && (cur_col == LAST_COL);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         mode_q <= MAG;
         col    <= '0;
         row    <= '0;
      end else if (accept) begin
         if (i_sof) begin
            mode_q <= decode_mode(i_mode);
         end
         if (cur_col == LAST_COL) begin
            col <= '0;
            row <= cur_row + RW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
         if (i_sof) begin
            state <= FILL;
         end else if (state == FILL && cur_row == RW'(1) && cur_col == LAST_COL) begin
            state <= RUN;
         end else if (at_last) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
         end
      end
   end

   // win[0] is the current line, win[2] two lines up; column 0 is newest.
   logic [DATA_WIDTH-1:0] win [3][3];
   logic [DATA_WIDTH-1:0] line0_out;
   logic [DATA_WIDTH-1:0] line1_out;

   line_fifo #(.DEPTH(IMG_WIDTH - 3), .WIDTH(DATA_WIDTH)) u_line0 (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .shift_en (accept),
      .wr_data  (win[0][2]),
      .rd_data  (line0_out)
   );

   line_fifo #(.DEPTH(IMG_WIDTH - 3), .WIDTH(DATA_WIDTH)) u_line1 (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .shift_en (accept),
      .wr_data  (win[1][2]),
      .rd_data  (line1_out)
   );

   always_ff @(posedge i_clk) begin
      if (accept) begin
         win[0][0] <= i_data;
         win[1][0] <= line0_out;
         win[2][0] <= line1_out;
         for (int r = 0; r < 3; r++) begin
            win[2'(r)][2] <= win[2'(r)][1];
            win[2'(r)][1] <= win[2'(r)][0];
         end
      end
   end

   logic v0;
   logic last0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v0    <= 1'b0;
         last0 <= 1'b0;
      end else begin
         v0    <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
         last0 <= accept && at_last;
      end
   end

   logic signed [SW-1:0] gx;
   logic signed [SW-1:0] gy;
   logic signed [SW-1:0] px;
   logic        [SW-1:0] abs_gx;
   logic        [SW-1:0] abs_gy;
   logic        [SW-1:0] mag;
   logic        [OW-1:0] result;
`ifdef EDGE_CONV_SATURATE_EN
   localparam int SAT_MAX = (2 ** DATA_WIDTH) - 1;
`endif

   // NOTE: every variable gets a default before the loop so no latch is
   // inferred; the blocking updates here accumulate within one evaluation.
   always_comb begin
      gx = '0;
      gy = '0;
      px = '0;
      for (int kr = 0; kr < 3; kr++) begin
         for (int kc = 0; kc < 3; kc++) begin
            px = SW'(win[2'(2 - kr)][2'(2 - kc)]);
            gx = gx + SW'(GX_COEF[2'(kr)][2'(kc)]) * px;
            gy = gy + SW'(GY_COEF[2'(kr)][2'(kc)]) * px;
         end
      end
      abs_gx = gx[SW-1] ? SW'(-gx) : SW'(gx);
      abs_gy = gy[SW-1] ? SW'(-gy) : SW'(gy);
      case (mode_q)
         GX:      mag = abs_gx;
         GY:      mag = abs_gy;
         default: mag = abs_gx + abs_gy;
      endcase
`ifdef EDGE_CONV_SATURATE_EN
      result = (mag > SW'(SAT_MAX)) ? OW'(SAT_MAX) : OW'(mag);
`else
      result = OW'(mag);
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_valid      <= v0;
         o_frame_done <= last0;
         if (v0) begin
            o_data <= result;
         end
      end
   end

endmodule

// File: tb/tb_edge_conv_pipe.sv
// Self-checking bench for edge_conv_pipe: directed and random frames compared
// cycle by cycle against a frame-array Sobel model.
module tb_edge_conv_pipe;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 12;
   localparam int OW = DW + 3;
`ifdef EDGE_CONV_SATURATE_EN
   localparam int PEAK_4095 = 4095;
`else
   localparam int PEAK_4095 = 16380;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid;
   logic          i_sof;
   logic [DW-1:0] i_data;
   logic [1:0]    i_mode;
   logic          o_valid;
   logic [OW-1:0] o_data;
   logic          o_frame_done;

   edge_conv_pipe #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .i_sof        (i_sof),
      .i_data       (i_data),
      .i_mode       (i_mode),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_frame_done (o_frame_done)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: the current frame as an image plus a raster index.
   int img [H][W];
   bit in_frame = 1'b0;
   int pos = 0;
   int mode_m = 0;

   // Result due on the outputs at the next sample point.
   bit exp_v = 1'b0;
   bit exp_done = 1'b0;
   int exp_data = 0;

   int n_res;
   int n_done;
   int max_res;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Sobel response at centre (r-1,c-1) of the stored frame.
   function automatic int model_result(input int r, input int c, input int md);
      int gx, gy, m;
      gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
      case (md)
         0:       m = iabs(gx);
         1:       m = iabs(gy);
         default: m = iabs(gx) + iabs(gy);
      endcase
`ifdef EDGE_CONV_SATURATE_EN
      if (m > 4095) m = 4095;
`endif
      return m;
   endfunction

   function automatic int pix(input int kind, input int r, input int c);
      case (kind)
         0:       return (c >= 4) ? 100 : 0;
         1:       return (r >= 3) ? 100 : 0;
         2:       return 500;
         3:       return (c >= 4) ? 4095 : 0;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   // One clock: drive inputs, update the model, check the outputs after the edge.
   task automatic step(input bit v, input bit sof, input int data, input int md);
      bit nv, nd;
      int ndata, r, c;
      i_valid = v;
      i_sof   = sof;
      i_data  = DW'(data);
      i_mode  = 2'(md);
      nv = 1'b0;
      nd = 1'b0;
      ndata = 0;
      if (v) begin
         if (sof) begin
            in_frame = 1'b1;
            pos      = 0;
            mode_m   = md;
         end
         if (in_frame) begin
            r = pos / W;
            c = pos % W;
            img[r][c] = data;
            if (r >= 2 && c >= 2) begin
               nv    = 1'b1;
               ndata = model_result(r, c, mode_m);
            end
            if (pos == W * H - 1) begin
               nd       = 1'b1;
               in_frame = 1'b0;
            end
            pos++;
         end
      end
      @(posedge i_clk);
      #1;
      check("o_valid", 32'(o_valid), 32'(exp_v));
      check("o_frame_done", 32'(o_frame_done), 32'(exp_done));
      if (exp_v) check("o_data", 32'(o_data), 32'(exp_data));
      if (o_valid) begin
         n_res++;
         if (int'(o_data) > max_res) max_res = int'(o_data);
      end
      if (o_frame_done) n_done++;
      exp_v    = nv;
      exp_done = nd;
      exp_data = ndata;
   endtask

   task automatic send_frame(input int kind, input int md, input int max_gap, input int npix);
      for (int p = 0; p < npix; p++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 3)));
         end
         step(1'b1, p == 0, pix(kind, p / W, p % W),
              (p == 0) ? md : int'($urandom_range(0, 3)));
      end
   endtask

   task automatic drain();
      repeat (3) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic clear_stats();
      n_res   = 0;
      n_done  = 0;
      max_res = 0;
   endtask

   task automatic reset_now();
      #2;
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      #1;
      check("rst o_valid", 32'(o_valid), 32'd0);
      check("rst o_data", 32'(o_data), 32'd0);
      check("rst o_frame_done", 32'(o_frame_done), 32'd0);
      exp_v    = 1'b0;
      exp_done = 1'b0;
      in_frame = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      int mg;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_data  = '0;
      i_mode  = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("init o_valid", 32'(o_valid), 32'd0);
      check("init o_data", 32'(o_data), 32'd0);
      check("init o_frame_done", 32'(o_frame_done), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Directed frames, first back-to-back then with random idle gaps.
      for (int pass = 0; pass < 2; pass++) begin
         mg = pass * 5;
         clear_stats();
         send_frame(0, 0, mg, W * H);
         drain();
         check("vstep results", 32'(n_res), 32'd24);
         check("vstep done", 32'(n_done), 32'd1);
         check("vstep peak", 32'(max_res), 32'd400);

         clear_stats();
         send_frame(1, 1, mg, W * H);
         drain();
         check("hstep results", 32'(n_res), 32'd24);
         check("hstep peak", 32'(max_res), 32'd400);

         clear_stats();
         send_frame(2, 2, mg, W * H);
         drain();
         check("flat results", 32'(n_res), 32'd24);
         check("flat peak", 32'(max_res), 32'd0);

         clear_stats();
         send_frame(3, 2, mg, W * H);
         drain();
         check("edge4095 peak", 32'(max_res), 32'(PEAK_4095));
         check("edge4095 done", 32'(n_done), 32'd1);
      end

      // Abort at (3,5) with a mode switch: 9 old results then a full new frame.
      clear_stats();
      send_frame(0, 0, 0, 3 * W + 5);
      send_frame(1, 1, 2, W * H);
      drain();
      check("abort results", 32'(n_res), 32'd33);
      check("abort done", 32'(n_done), 32'd1);

      // Start of frame landing on the final pixel slot restarts the frame.
      clear_stats();
      send_frame(4, 3, 0, W * H - 1);
      send_frame(4, 0, 1, W * H);
      drain();
      check("lastpos results", 32'(n_res), 32'd47);
      check("lastpos done", 32'(n_done), 32'd1);

      // Reset mid-frame, then pixels without a start of frame are ignored.
      send_frame(0, 0, 0, 30);
      reset_now();
      clear_stats();
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, int'($urandom_range(0, 4095)), 2);
      check("post-reset idle", 32'(n_res), 32'd0);
      send_frame(3, 2, 3, W * H);
      drain();
      check("post-reset results", 32'(n_res), 32'd24);
      check("post-reset done", 32'(n_done), 32'd1);

      // Random images in random modes with random gaps.
      for (int f = 0; f < 4; f++) begin
         clear_stats();
         send_frame(4, int'($urandom_range(0, 3)), 3, W * H);
         drain();
         check("random results", 32'(n_res), 32'd24);
         check("random done", 32'(n_done), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/edge_conv_pipe.md
EDGE_CONV_PIPE -- requirements
Module: edge_conv_pipe

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line; must be at least 4.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame; must be at least 3.
REQ-003 Parameter DATA_WIDTH, default 12: input pixel width, unsigned.
REQ-004 i_clk  in  1  clock; all state updates on the rising edge.
REQ-005 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 i_valid  in  1  input pixel valid; no backpressure, so every asserted cycle is accepted.
REQ-007 i_sof  in  1  start-of-frame; qualified by i_valid; marks pixel (0,0).
REQ-008 i_data  in  DATA_WIDTH  pixel value, raster order.
REQ-009 i_mode  in  2  kernel select: 0=Gx, 1=Gy, 2=|Gx|+|Gy|, 3=reserved (treated as 2); sampled only with i_sof.
REQ-010 o_valid  out  1  output result valid, a single-cycle pulse per result.
REQ-011 o_data  out  DATA_WIDTH+3  unsigned result magnitude.
REQ-012 o_frame_done  out  1  one-cycle pulse aligned with the last result of a complete frame.

Function
REQ-013 Frame FSM states:
- IDLE: waiting for a frame.
- FILL: rows 0..1.
- RUN: rows 2..IMG_HEIGHT-1.
REQ-014 Transitions:
- Any state -> FILL on i_valid&&i_sof.
- FILL -> RUN after pixel (1,IMG_WIDTH-1).
- RUN -> IDLE after pixel (IMG_HEIGHT-1,IMG_WIDTH-1).
REQ-015 In IDLE, i_valid without i_sof is discarded: no counter, buffer or output change.
REQ-016 Column/row counters advance only on accepted pixels; column wraps at IMG_WIDTH-1 to 0 and increments row.
REQ-017 A 3x3 window is built from two line buffers plus a 3-column shift register; all advance only on accepted pixels, so i_valid gaps are transparent.
REQ-018 A result is produced for the window centred at (r-1,c-1) when pixel (r,c) with r>=2 and c>=2 is accepted; no result for border centres.
REQ-019 Latency: o_valid is asserted exactly 2 cycles after the accepting cycle; the pipeline is free-running.
REQ-020 Kernels:
- Gx rows: [-1 0 1], [-2 0 2], [-1 0 1].
- Gy rows: [-1 -2 -1], [0 0 0], [1 2 1].
REQ-021 Kernel sums use signed DATA_WIDTH+4-bit arithmetic; no intermediate overflow.
REQ-022 Mode 0/1 output = |sum|; mode 2 output = |Gx|+|Gy|; maximum 8*(2^DATA_WIDTH-1) fits DATA_WIDTH+3 bits.
REQ-023 Mode is latched at i_sof and is constant for the frame; i_mode is ignored at other times.
REQ-024 i_sof mid-frame aborts the current frame:
- Counters restart at (0,0) with the new pixel.
- Already-issued pipeline results still emerge.
- The aborted frame gives no o_frame_done.
REQ-025 i_sof at pixel (IMG_HEIGHT-1,IMG_WIDTH-1) position is treated as a new frame start, not the last pixel.
REQ-026 Line-buffer contents from a previous frame never contribute to a new frame's results, because no result is emitted before row 2.

Reset
REQ-027 During reset:
- The FSM is IDLE and the counters are 0.
- o_valid=0, o_data=0, o_frame_done=0.
- Pipeline valid bits are cleared.
REQ-028 Line-buffer storage is not required to be reset.
REQ-029 Reset mid-frame drops all in-flight results; after release, operation requires a new i_sof.

Configuration
REQ-030 Macro EDGE_CONV_SATURATE_EN:
- Defined: o_data is clamped to 2^DATA_WIDTH-1, with the upper 3 bits always 0.
- Undefined: o_data carries the full unclamped magnitude.
- Latency is identical in both cases.

Structure
REQ-031 Shared package edge_conv_pkg holds:
- the mode enum (GX, GY, MAG);
- the FSM state enum;
- the Gx/Gy kernel coefficient constants.
REQ-032 One sub-module, line_fifo, SHALL be used:
- Circular RAM buffer of depth IMG_WIDTH-3, width DATA_WIDTH.
- Shift-enable and wrap-around pointer.
- Instantiated twice, cascaded.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=12)
REQ-033 Reset check: assert reset mid-frame -> outputs 0 immediately; no o_valid until a new i_sof plus 2 rows+2 pixels.
REQ-034 Vertical step (cols 0-3=0, cols 4-7=100), mode 0:
- 24 results.
- Centres at cols 3 and 4 give 400; all others give 0.
- o_frame_done on the 24th result.
REQ-035 Horizontal step (rows 0-2=0, rows 3-5=100):
- Mode 1: centre rows 2 and 3 give 400, others 0.
- Mode 2 on a constant 500 image: all 24 results 0.
REQ-036 Step 0/4095 vertical edge, mode 2 -> peak result:
- 4095 with EDGE_CONV_SATURATE_EN.
- 16380 without it.
REQ-037 Same frames with random i_valid gaps (0-5 idle cycles) -> identical result sequence, each 2 cycles after its accepting pixel.
REQ-038 New i_sof at row 3 col 5 with mode switched:
- Old-frame results stop after the 2-cycle drain.
- The new frame yields 24 results in the new mode.
- Exactly one o_frame_done.
